fp_mult_pipe: RTL

- Parametrised, pipelined IEEE-754-style floating-point multiplier. It generalises the fixed 32-bit single-precision multiplier to arbitrary exponent and mantissa widths.
- Adds valid/ready streaming, round-to-nearest-even, special-value handling and exception flags.
- Sits between operand producers (PE array feeders) and the PE accumulate path.
- Sustains one product per cycle under no backpressure.

---
 rtl/fp_mult_pkg.sv | 40 ++++
 rtl/fp_mult_if.sv | 33 +++
 rtl/fp_unpack.sv | 51 +++++
 rtl/fp_mult_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// ----------------------------------------------------------------------------
// fp_mult_pkg
// Shared types and constants for the parametrised floating-point multiplier:
//   - fp_class_e : operand classification produced by fp_unpack
//   - FLG_*      : bit positions inside the 4-bit {nv, of, uf, nx} flag word
//   - canon_nan  : canonical quiet NaN for any exponent/mantissa width
// ----------------------------------------------------------------------------
package fp_mult_pkg;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      NORM = 3'd1,
      INF  = 3'd2,
      QNAN = 3'd3,
      SNAN = 3'd4
   } fp_class_e;

   localparam int FLG_NV = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   // Widest word canon_nan can describe; callers cast down to their width.
   localparam int NAN_MAX_W = 128;

   // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
   function automatic logic [NAN_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
      logic [NAN_MAX_W-1:0] v;
      v = {NAN_MAX_W{1'b0}};
      for (int i = 0; i < NAN_MAX_W; i++) begin
         if ((i >= man_w - 1) && (i < man_w + exp_w)) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/fp_mult_if.sv
// ----------------------------------------------------------------------------
// fp_mult_if
// Streaming bundle for fp_mult_pipe: operand side (in_valid/in_ready/a/b) and
// result side (out_valid/out_ready/result/flags).
//   master : operand producer + result consumer (drives a, b, out_ready)
//   slave  : the multiplier itself
// ----------------------------------------------------------------------------
interface fp_mult_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );

endinterface

// File: rtl/fp_unpack.sv
// ----------------------------------------------------------------------------
// fp_unpack
// Combinational split of one packed operand into sign/exponent/mantissa and
// classification. Denormals (exp == 0, man != 0) are reported as ZERO so the
// datapath flushes them.
//   i_op    : packed operand {sign, exp, man}
//   o_sign  : sign bit
//   o_exp   : biased exponent field
//   o_man   : stored mantissa (hidden bit excluded)
//   o_class : ZERO / NORM / INF / QNAN / SNAN
// ----------------------------------------------------------------------------
module fp_unpack
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] i_op,
   output logic                 o_sign,
   output logic [EXP_W-1:0]     o_exp,
   output logic [MAN_W-1:0]     o_man,
   output fp_class_e            o_class
);

   localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};

   assign o_sign = i_op[EXP_W+MAN_W];
   assign o_exp  = i_op[MAN_W +: EXP_W];
   assign o_man  = i_op[MAN_W-1:0];

   // Classify; a NaN is quiet when the mantissa MSB is set.
   always_comb begin
      o_class = NORM;
      if (o_exp == EXP_ZERO) begin
         o_class = ZERO;
      end else if (o_exp == EXP_ONES) begin
         if (o_man == MAN_ZERO) begin
            o_class = INF;
         end else if (o_man[MAN_W-1]) begin
            o_class = QNAN;
         end else begin
            o_class = SNAN;
         end
      end else begin
         o_class = NORM;
      end
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// ----------------------------------------------------------------------------
// fp_mult_pipe
// Three-stage pipelined floating-point multiplier with valid/ready streaming,
// round-to-nearest-even, flush-to-zero inputs/outputs and exception flags.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fp_mult_if slave (in_valid/in_ready/a/b, out_valid/out_ready/
//         result/flags {nv, of, uf, nx})
// Stages: S1 unpack/classify/exponent/special outcome, S2 mantissa product,
// S3 normalise/round/pack into the output register.
// ----------------------------------------------------------------------------
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic     clk,
   input logic     rst,
   fp_mult_if.slave bus
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW  = EXP_W + 2;           // signed exponent working width
   localparam int PW  = 2 * (MAN_W + 1);     // product width

   localparam logic [W-1:0]        CANON_NAN = W'(canon_nan(EXP_W, MAN_W));
   localparam logic [EXP_W-1:0]    EXP_ZERO  = {EXP_W{1'b0}};
   localparam logic [EXP_W-1:0]    EXP_ONES  = {EXP_W{1'b1}};
   localparam logic [MAN_W-1:0]    MAN_ZERO  = {MAN_W{1'b0}};
   localparam logic signed [EW-1:0] BIAS_S    = EW'((2 ** (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX_S = EW'((2 ** EXP_W) - 1);
   localparam logic signed [EW-1:0] EZERO_S   = {EW{1'b0}};

   // ---------------- S1: unpack, classify, exponent, specials ----------------
   logic               w_sa, w_sb;
   logic [EXP_W-1:0]   w_ea, w_eb;
   logic [MAN_W-1:0]   w_ma, w_mb;
   fp_class_e          w_ca, w_cb;
   logic               w_sign;
   logic signed [EW-1:0] w_exp_sum;
   logic               w_spec;
   logic [W-1:0]       w_sres;
   logic [3:0]         w_sflg;

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
      .i_op(bus.a), .o_sign(w_sa), .o_exp(w_ea), .o_man(w_ma), .o_class(w_ca)
   );

   fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
      .i_op(bus.b), .o_sign(w_sb), .o_exp(w_eb), .o_man(w_mb), .o_class(w_cb)
   );

   assign w_sign    = w_sa ^ w_sb;
   assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_S;

   // Special-case outcome in priority order: NaN, INF*ZERO, INF, ZERO.
   always_comb begin
      w_spec = 1'b1;
      w_sres = CANON_NAN;
      w_sflg = 4'b0000;
      if ((w_ca == QNAN) || (w_ca == SNAN) || (w_cb == QNAN) || (w_cb == SNAN)) begin
         w_sres         = CANON_NAN;
         w_sflg[FLG_NV] = (w_ca == SNAN) || (w_cb == SNAN);
      end else if (((w_ca == INF) && (w_cb == ZERO)) || ((w_ca == ZERO) && (w_cb == INF))) begin
         w_sres         = CANON_NAN;
         w_sflg[FLG_NV] = 1'b1;
      end else if ((w_ca == INF) || (w_cb == INF)) begin
         w_sres = {w_sign, EXP_ONES, MAN_ZERO};
      end else if ((w_ca == ZERO) || (w_cb == ZERO)) begin
         w_sres = {w_sign, EXP_ZERO, MAN_ZERO};
      end else begin
         w_spec = 1'b0;
         w_sres = CANON_NAN;
      end
   end

   // ---------------- handshake ----------------
   // Each stage can load when it is empty or its contents move on this cycle.
   logic r_v1, r_v2, r_v3;
   logic w_en1, w_en2, w_en3;

   assign w_en3        = !r_v3 || bus.out_ready;
   assign w_en2        = !r_v2 || w_en3;
   assign w_en1        = !r_v1 || w_en2;
   assign bus.in_ready = w_en1;

   // ---------------- S1 registers ----------------
   logic                 r_sign1, r_spec1;
   logic signed [EW-1:0] r_exp1;
   logic [MAN_W:0]       r_ma1, r_mb1;
   logic [W-1:0]         r_sres1;
   logic [3:0]           r_sflg1;

   // Stage 1 capture of classified operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_sign1 <= 1'b0;
         r_spec1 <= 1'b0;
         r_exp1  <= EZERO_S;
         r_ma1   <= {(MAN_W+1){1'b0}};
         r_mb1   <= {(MAN_W+1){1'b0}};
         r_sres1 <= {W{1'b0}};
         r_sflg1 <= 4'b0000;
      end else if (w_en1) begin
         r_v1 <= bus.in_valid;
         if (bus.in_valid) begin
            r_sign1 <= w_sign;
            r_spec1 <= w_spec;
            r_exp1  <= w_exp_sum;
            r_ma1   <= {1'b1, w_ma};
            r_mb1   <= {1'b1, w_mb};
            r_sres1 <= w_sres;
            r_sflg1 <= w_sflg;
         end
      end
   end

   // ---------------- S2: mantissa product ----------------
   logic [PW-1:0]        w_prod;
   logic                 r_sign2, r_spec2;
   logic signed [EW-1:0] r_exp2;
   logic [PW-1:0]        r_prod2;
   logic [W-1:0]         r_sres2;
   logic [3:0]           r_sflg2;

   assign w_prod = {{(MAN_W+1){1'b0}}, r_ma1} * {{(MAN_W+1){1'b0}}, r_mb1};

   // Stage 2 capture of the full-width product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v2    <= 1'b0;
         r_sign2 <= 1'b0;
         r_spec2 <= 1'b0;
         r_exp2  <= EZERO_S;
         r_prod2 <= {PW{1'b0}};
         r_sres2 <= {W{1'b0}};
         r_sflg2 <= 4'b0000;
      end else if (w_en2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_sign2 <= r_sign1;
            r_spec2 <= r_spec1;
            r_exp2  <= r_exp1;
            r_prod2 <= w_prod;
            r_sres2 <= r_sres1;
            r_sflg2 <= r_sflg1;
         end
      end
   end

   // ---------------- S3: normalise, round, pack ----------------
   logic                 w_msb;
   logic [MAN_W-1:0]     w_man_k;
   logic                 w_g, w_r, w_s, w_inc;
   logic [MAN_W:0]       w_man_rnd;
   logic signed [EW-1:0] w_exp_fin;
   logic [W-1:0]         w_res3;
   logic [3:0]           w_flg3;

   assign w_msb = r_prod2[PW-1];

   // Pick kept mantissa and G/R/S from the product; a product in [2,4) is
   // taken one bit higher, which is the right shift of the normalisation.
   always_comb begin
      if (w_msb) begin
         w_man_k = r_prod2[2*MAN_W : MAN_W+1];
         w_g     = r_prod2[MAN_W];
         w_r     = r_prod2[MAN_W-1];
         w_s     = |r_prod2[MAN_W-2:0];
      end else begin
         w_man_k = r_prod2[2*MAN_W-1 : MAN_W];
         w_g     = r_prod2[MAN_W-1];
         w_r     = r_prod2[MAN_W-2];
         w_s     = |r_prod2[MAN_W-3:0];
      end
   end

   // Nearest-even increment; on carry-out the stored mantissa is already zero
   // and only the exponent needs the extra +1.
   assign w_inc     = w_g && (w_r || w_s || w_man_k[0]);
   assign w_man_rnd = {1'b0, w_man_k} + {{MAN_W{1'b0}}, w_inc};
   assign w_exp_fin = r_exp2 + $signed({{(EW-1){1'b0}}, w_msb})
                             + $signed({{(EW-1){1'b0}}, w_man_rnd[MAN_W]});

   // Final result selection: special, overflow, underflow or normal.
   always_comb begin
      w_res3 = {W{1'b0}};
      w_flg3 = 4'b0000;
      if (r_spec2) begin
         w_res3 = r_sres2;
         w_flg3 = r_sflg2;
      end else if (w_exp_fin >= EXP_MAX_S) begin
         w_res3         = {r_sign2, EXP_ONES, MAN_ZERO};
         w_flg3[FLG_OF] = 1'b1;
         w_flg3[FLG_NX] = 1'b1;
      end else if (w_exp_fin <= EZERO_S) begin
         w_res3         = {r_sign2, EXP_ZERO, MAN_ZERO};
         w_flg3[FLG_UF] = 1'b1;
         w_flg3[FLG_NX] = 1'b1;
      end else begin
         w_res3         = {r_sign2, w_exp_fin[EXP_W-1:0], w_man_rnd[MAN_W-1:0]};
         w_flg3[FLG_NX] = w_g || w_r || w_s;
      end
   end

   logic [W-1:0] r_res3;
   logic [3:0]   r_flg3;

   // Output register; holds while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v3   <= 1'b0;
         r_res3 <= {W{1'b0}};
         r_flg3 <= 4'b0000;
      end else if (w_en3) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_res3 <= w_res3;
            r_flg3 <= w_flg3;
         end
      end
   end

   assign bus.out_valid = r_v3;
   assign bus.result    = r_res3;
   assign bus.flags     = r_flg3;

endmodule
